// File: rtl/mem_access_if.sv
// Shared op type and the bus bundle for the memory-access stage.
//
// mem_access_pkg
//   decoded_op_t  op record passed from execute to reg_writeback
//   BUBBLE        op that makes reg_writeback write nothing (store=1, rest 0)
//
// mem_access_if  (signal names match the original stage ports)
//   pipeline in : i_valid, i_op           pipeline out: o_ready, o_valid, o_op
//   data port   : o_dmem_req/we/addr/wdata/be out, i_dmem_gnt/rvalid/rdata in
//   status      : o_misaligned
//   modport slave  - the stage itself
//   modport master - the environment (execute, reg_writeback, memory)

package mem_access_pkg;

    typedef struct packed {
        logic [4:0]  rdest;
        logic        load;
        logic        store;
        logic [2:0]  mem_size;
        logic [31:0] rs2_data;
        logic [31:0] ex_result;
    } decoded_op_t;

    localparam decoded_op_t BUBBLE = '{
        rdest:     '0,
        load:      1'b0,
        store:     1'b1,
        mem_size:  '0,
        rs2_data:  '0,
        ex_result: '0
    };

endpackage

interface mem_access_if;
    import mem_access_pkg::*;

    logic        i_valid;
    logic        o_ready;
    decoded_op_t i_op;
    logic        o_valid;
    decoded_op_t o_op;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_misaligned;

    modport slave (
        input  i_valid, i_op, i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
        output o_ready, o_valid, o_op, o_dmem_req, o_dmem_we, o_dmem_addr,
               o_dmem_wdata, o_dmem_be, o_misaligned
    );

    modport master (
        output i_valid, i_op, i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
        input  o_ready, o_valid, o_op, o_dmem_req, o_dmem_we, o_dmem_addr,
               o_dmem_wdata, o_dmem_be, o_misaligned
    );

endinterface

// File: rtl/mem_access.sv
// Memory stage between execute and reg_writeback.
// Accepts one op per i_valid & o_ready handshake. Non-memory ops pass through
// with one register stage; aligned loads/stores go out on a req/gnt/rvalid
// data port while upstream is stalled; misaligned accesses are dropped with a
// one-cycle o_misaligned pulse. Loads return with ex_result replaced by the
// lane-extracted load data.
//
// Ports
//   clk    in  clock
//   rst_n  in  synchronous reset, active-low
//   bus    mem_access_if.slave (pipeline handshake, data port, misaligned flag)
//
// Parameter
//   wd_regs_p  data/address width, only 32 is supported

module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned wd_regs_p = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    decoded_op_t op_hold;
    decoded_op_t op_hold_next;
    decoded_op_t out_op;
    decoded_op_t out_op_next;
    decoded_op_t loaded_op;
    logic        out_valid;
    logic        out_valid_next;
    logic        mis;
    logic        mis_next;

    logic [1:0]           off;
    logic [1:0]           in_off;
    logic                 in_misaligned;
    logic [3:0]           lane_be;
    logic [wd_regs_p-1:0] lane_wdata;
    logic [7:0]           lane_byte;
    logic [15:0]          lane_half;
    logic [wd_regs_p-1:0] load_value;

    assign off    = op_hold.ex_result[1:0];
    assign in_off = bus.i_op.ex_result[1:0];

    // Alignment is judged on mem_size[1:0]: the unsigned load codes share the
    // low bits of their signed counterparts, everything else is word-sized.
    always_comb begin
        unique case (bus.i_op.mem_size[1:0])
            2'b00:   in_misaligned = 1'b0;
            2'b01:   in_misaligned = in_off[0];
            default: in_misaligned = (in_off != 2'b00);
        endcase
    end

    always_comb begin
        unique case (op_hold.mem_size[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << off;
                lane_wdata = {4{op_hold.rs2_data[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << off;
                lane_wdata = {2{op_hold.rs2_data[15:0]}};
            end
            default: begin
                lane_be    = 4'hF;
                lane_wdata = op_hold.rs2_data;
            end
        endcase
    end

    // Only aligned accesses reach the port, so a half lane is picked by off[1].
    assign lane_byte = bus.i_dmem_rdata[{off, 3'b000} +: 8];
    assign lane_half = off[1] ? bus.i_dmem_rdata[31:16] : bus.i_dmem_rdata[15:0];

    always_comb begin
        unique case (op_hold.mem_size)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_value = {24'h000000, lane_byte};
            3'b101:  load_value = {16'h0000, lane_half};
            default: load_value = bus.i_dmem_rdata;
        endcase
    end

    always_comb begin
        loaded_op           = op_hold;
        loaded_op.ex_result = load_value;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_hold   <= '0;
            out_valid <= 1'b0;
            out_op    <= BUBBLE;
            mis       <= 1'b0;
        end else begin
            state     <= state_next;
            op_hold   <= op_hold_next;
            out_valid <= out_valid_next;
            out_op    <= out_op_next;
            mis       <= mis_next;
        end
    end

    always_comb begin
        state_next     = state;
        op_hold_next   = op_hold;
        out_valid_next = 1'b0;
        out_op_next    = BUBBLE;
        mis_next       = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    if (!bus.i_op.load && !bus.i_op.store) begin
                        out_valid_next = 1'b1;
                        out_op_next    = bus.i_op;
                    end else if (in_misaligned) begin
                        mis_next = 1'b1;
                    end else begin
                        op_hold_next = bus.i_op;
                        state_next   = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.i_dmem_gnt) begin
                    if (op_hold.store) begin
                        out_valid_next = 1'b1;
                        out_op_next    = op_hold;
                        state_next     = IDLE;
                    end else if (bus.i_dmem_rvalid) begin
                        out_valid_next = 1'b1;
                        out_op_next    = loaded_op;
                        state_next     = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.i_dmem_rvalid) begin
                    out_valid_next = 1'b1;
                    out_op_next    = loaded_op;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields come straight from the held op, so they stay stable for
    // the whole REQ state and read as zero everywhere else.
    assign bus.o_ready      = (state == IDLE);
    assign bus.o_dmem_req   = (state == REQ);
    assign bus.o_dmem_we    = (state == REQ) && op_hold.store;
    assign bus.o_dmem_addr  = (state == REQ) ? {op_hold.ex_result[31:2], 2'b00} : '0;
    assign bus.o_dmem_wdata = (state == REQ) ? lane_wdata : '0;
    assign bus.o_dmem_be    = (state == REQ) ? lane_be : '0;
    assign bus.o_valid      = out_valid;
    assign bus.o_op         = out_op;
    assign bus.o_misaligned = mis;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    logic clk;
    logic rst_n;

    mem_access_if bus ();

    mem_access #(.wd_regs_p(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          mis;
        decoded_op_t op;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];

    logic [31:0] ram     [16];
    logic [31:0] ref_mem [16];

    int total = 0;
    int bad   = 0;

    // responder knobs: -1 means random
    int gnt_delay_k = -1;
    int same_k      = -1;
    bit hold_rvalid = 1'b0;
    bit stray_en    = 1'b0;
    bit rvalid_due  = 1'b0;

    logic [31:0] last_ex;
    logic [3:0]  last_be;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what an accepted op must eventually produce.
    task automatic model(input decoded_op_t op);
        exp_t        e;
        req_t        r;
        logic [31:0] a;
        logic [31:0] w;
        int unsigned nb;
        int unsigned o;
        int unsigned idx;
        a   = op.ex_result;
        o   = a % 4;
        idx = (a / 4) % 16;
        nb  = (op.mem_size[1:0] == 2'b00) ? 1 : (op.mem_size[1:0] == 2'b01) ? 2 : 4;
        e.mis = 1'b0;
        e.op  = op;
        if (!op.load && !op.store) begin
            exp_q.push_back(e);
        end else if ((a % nb) != 0) begin
            e.mis = 1'b1;
            e.op  = BUBBLE;
            exp_q.push_back(e);
        end else begin
            r.we    = op.store;
            r.addr  = a - o;
            r.be    = 4'(((1 << nb) - 1) << o);
            r.wdata = '0;
            if (op.store) begin
                for (int j = 0; j < 4; j++)
                    r.wdata[8*j +: 8] = op.rs2_data[8*(j % nb) +: 8];
                for (int k = 0; k < nb; k++)
                    ref_mem[idx][8*(o+k) +: 8] = op.rs2_data[8*k +: 8];
            end else begin
                w = ref_mem[idx] >> (8 * o);
                case (op.mem_size)
                    3'd0: begin w = w & 32'hFF;   if (w >= 32'h80)   w = w - 32'h100;   end
                    3'd1: begin w = w & 32'hFFFF; if (w >= 32'h8000) w = w - 32'h10000; end
                    3'd4: w = w & 32'hFF;
                    3'd5: w = w & 32'hFFFF;
                    default: w = ref_mem[idx];
                endcase
                e.op.ex_result = w;
            end
            req_q.push_back(r);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input decoded_op_t op);
        int unsigned n = 0;
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        while (!bus.o_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept", bus.o_ready, 1);
        if (bus.o_ready) begin
            model(op);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || !bus.o_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    function automatic decoded_op_t mk(input bit ld, input bit st, input logic [2:0] sz,
                                       input logic [31:0] addr, input logic [31:0] rs2);
        decoded_op_t op;
        op           = '0;
        op.rdest     = 5'd3;
        op.load      = ld;
        op.store     = st;
        op.mem_size  = sz;
        op.ex_result = addr;
        op.rs2_data  = rs2;
        return op;
    endfunction

    function automatic decoded_op_t rand_op();
        decoded_op_t op;
        int unsigned k;
        k            = $urandom_range(0, 2);
        op.rdest     = 5'($urandom);
        op.rs2_data  = $urandom;
        op.ex_result = $urandom;
        op.mem_size  = 3'($urandom);
        op.load      = (k == 1);
        op.store     = (k == 2);
        if (k != 0) begin
            op.ex_result = $urandom & 32'h3FF;
            if ($urandom_range(0, 3) != 0) begin
                if (op.mem_size[1:0] == 2'b01)
                    op.ex_result[0] = 1'b0;
                else if (op.mem_size[1:0] != 2'b00)
                    op.ex_result[1:0] = 2'b00;
            end
        end
        return op;
    endfunction

    // Monitor: pops one expectation per output event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!bus.o_valid)
                    chk("bubble", bus.o_op, BUBBLE);
                if (bus.o_valid || bus.o_misaligned) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", {bus.o_valid, bus.o_misaligned}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.mis) begin
                            chk("mis_pulse", {bus.o_misaligned, bus.o_valid}, 2'b10);
                        end else begin
                            chk("out_flags", {bus.o_valid, bus.o_misaligned}, 2'b10);
                            chk("out_op", bus.o_op, e.op);
                            last_ex = bus.o_op.ex_result;
                        end
                    end
                end
            end
        end
    end

    // Data-port responder with its own memory image.
    initial begin
        bit          in_req    = 1'b0;
        bit          after_gnt = 1'b0;
        int          wait_cnt  = 0;
        int          lat       = 0;
        int unsigned idx;
        logic [31:0] pend_data = '0;
        req_t        r;
        bus.i_dmem_gnt    = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_rdata  = '0;
        forever begin
            @(posedge clk); #2;
            bus.i_dmem_gnt    = 1'b0;
            bus.i_dmem_rvalid = 1'b0;
            bus.i_dmem_rdata  = $urandom;
            if (after_gnt) begin
                chk("req_drop", bus.o_dmem_req, 0);
                after_gnt = 1'b0;
            end
            if (rvalid_due) begin
                if (!hold_rvalid) begin
                    if (lat == 0) begin
                        bus.i_dmem_rvalid = 1'b1;
                        bus.i_dmem_rdata  = pend_data;
                        rvalid_due        = 1'b0;
                    end else begin
                        lat--;
                    end
                end
            end else if (bus.o_dmem_req && rst_n) begin
                chk("req_pending", req_q.size(), 1);
                chk("stall_ready", bus.o_ready, 0);
                if (req_q.size() != 0) begin
                    r = req_q[0];
                    if (!in_req) begin
                        in_req   = 1'b1;
                        wait_cnt = (gnt_delay_k >= 0) ? gnt_delay_k : int'($urandom_range(0, 3));
                    end
                    chk("req_we", bus.o_dmem_we, r.we);
                    chk("req_addr", bus.o_dmem_addr, r.addr);
                    chk("req_be", bus.o_dmem_be, r.be);
                    if (r.we)
                        chk("req_wdata", bus.o_dmem_wdata, r.wdata);
                    if (wait_cnt == 0) begin
                        void'(req_q.pop_front());
                        in_req         = 1'b0;
                        after_gnt      = 1'b1;
                        bus.i_dmem_gnt = 1'b1;
                        last_be        = bus.o_dmem_be;
                        idx            = bus.o_dmem_addr[5:2];
                        if (bus.o_dmem_we) begin
                            for (int j = 0; j < 4; j++)
                                if (bus.o_dmem_be[j])
                                    ram[idx][8*j +: 8] = bus.o_dmem_wdata[8*j +: 8];
                        end else begin
                            pend_data = ram[idx];
                            if ((same_k >= 0) ? (same_k != 0) : ($urandom_range(0, 1) == 1)) begin
                                bus.i_dmem_rvalid = 1'b1;
                                bus.i_dmem_rdata  = pend_data;
                            end else begin
                                rvalid_due = 1'b1;
                                lat        = $urandom_range(0, 3);
                            end
                        end
                    end else begin
                        wait_cnt--;
                        if (stray_en && $urandom_range(0, 3) == 0)
                            bus.i_dmem_rvalid = 1'b1;
                    end
                end
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                bus.i_dmem_rvalid = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        decoded_op_t op;
        logic [31:0] w;
        int unsigned n;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_op    = '0;
        for (int i = 0; i < 16; i++) begin
            w          = $urandom;
            ram[i]     = w;
            ref_mem[i] = w;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_req", bus.o_dmem_req, 0);
        chk("rst_mis", bus.o_misaligned, 0);
        chk("rst_op", bus.o_op, BUBBLE);
        chk("rst_dmem", {bus.o_dmem_we, bus.o_dmem_addr, bus.o_dmem_wdata, bus.o_dmem_be}, '0);
        chk("rst_ready", bus.o_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // pass-through op
        op           = '0;
        op.rdest     = 5'd5;
        op.ex_result = 32'h1234;
        send(op);
        chk("alu_ready", bus.o_ready, 1);
        wait_idle();
        chk("alu_value", last_ex, 32'h1234);

        // word store with delayed grant
        gnt_delay_k = 3;
        same_k      = 0;
        send(mk(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF));
        wait_idle();
        chk("sw_mem", ram[0], 32'hDEADBEEF);

        // byte loads from the top lane
        ram[0]      = 32'h80FFFFFF;
        ref_mem[0]  = 32'h80FFFFFF;
        gnt_delay_k = 1;
        send(mk(1'b1, 1'b0, 3'b000, 32'h203, 32'h0));
        wait_idle();
        chk("lb_value", last_ex, 32'hFFFFFF80);
        chk("lb_be", last_be, 4'b1000);
        send(mk(1'b1, 1'b0, 3'b100, 32'h203, 32'h0));
        wait_idle();
        chk("lbu_value", last_ex, 32'h00000080);

        // half load, grant and data in the same cycle
        ram[0]      = 32'h7FFF0000;
        ref_mem[0]  = 32'h7FFF0000;
        gnt_delay_k = 0;
        same_k      = 1;
        send(mk(1'b1, 1'b0, 3'b001, 32'h202, 32'h0));
        @(posedge clk); #1;
        chk("lh_ready", bus.o_ready, 1);
        wait_idle();
        chk("lh_value", last_ex, 32'h00007FFF);

        // misaligned word load, next op straight after
        send(mk(1'b1, 1'b0, 3'b010, 32'h101, 32'h0));
        chk("mis_ready", bus.o_ready, 1);
        op           = '0;
        op.rdest     = 5'd9;
        op.ex_result = 32'hCAFE;
        send(op);
        wait_idle();

        // reset while waiting for load data, then a late rvalid
        hold_rvalid = 1'b1;
        same_k      = 0;
        send(mk(1'b1, 1'b0, 3'b010, 32'h40, 32'h0));
        n = 0;
        while (!rvalid_due && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_reached", rvalid_due, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        chk("midrst_req", bus.o_dmem_req, 0);
        chk("midrst_valid", bus.o_valid, 0);
        chk("midrst_ready", bus.o_ready, 1);
        hold_rvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("late_rvalid", bus.o_valid, 0);
        chk("late_ready", bus.o_ready, 1);

        // randomized traffic
        gnt_delay_k = -1;
        same_k      = -1;
        stray_en    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_op());
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        stray_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("req_q_empty", req_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
